// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// wb_port_arbiter_if : bundles the write-back request/grant bus of the
// register-file port arbiter. Revision: 1.0
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       req;
  logic             rf_stall;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic             wb_en;
  logic             busy;
  logic [CNT_W-1:0] grant_cnt;

  modport master (
    input  req,
    input  rf_stall,
    output grant,
    output sel,
    output wb_en,
    output busy,
    output grant_cnt
  );

  modport slave (
    output req,
    output rf_stall,
    input  grant,
    input  sel,
    input  wb_en,
    input  busy,
    input  grant_cnt
  );
endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// wb_port_arbiter : registered round-robin arbiter for the single register-file
// write-back port shared by ALU, load, mul/div and link producers. Revision: 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.master bus
);

  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             wb_en_q, wb_en_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       elig;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;

  // The producer holding the grant still has req high this cycle; mask it.
  assign elig = bus.req & ~grant_q;

  // Descending scan so the lowest rotation offset from ptr wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_d = '0;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    wb_en_d = 1'b0;
    busy_d  = 1'b0;
    cnt_d   = cnt_q;
    if (bus.rf_stall) begin
      busy_d = |elig;
    end else if (found) begin
      grant_d = 4'b0001 << win;
      sel_d   = win;
      ptr_d   = win + 2'd1;
      wb_en_d = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
      busy_d  = |(elig & ~(4'b0001 << win));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      wb_en_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      wb_en_q <= wb_en_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.busy      = busy_q;
  assign bus.grant_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// tb_wb_port_arbiter : directed stimulus with a scoreboard queue of expected
// registered outputs, popped by an independent monitor. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.CNT_W(CW)) bus ();

  wb_port_arbiter #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]    g;
    logic [1:0]    s;
    logic          en;
    logic          b;
    logic [CW-1:0] c;
    string         name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Monitor: every edge that has an outstanding expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (bus.grant === e.g && bus.sel === e.s && bus.wb_en === e.en &&
            bus.busy === e.b && bus.grant_cnt === e.c) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got grant=%b sel=%0d wb_en=%b busy=%b cnt=%0d, expected grant=%b sel=%0d wb_en=%b busy=%b cnt=%0d",
                   e.name, bus.grant, bus.sel, bus.wb_en, bus.busy, bus.grant_cnt,
                   e.g, e.s, e.en, e.b, e.c);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic [3:0] rq, input logic st,
                     input logic [3:0] g, input logic [1:0] s, input logic b,
                     input int c, input string nm);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.req      = rq;
    bus.rf_stall = st;
    e.g    = g;
    e.s    = s;
    e.en   = |g;
    e.b    = b;
    e.c    = CW'(c);
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    bus.req      = 4'b0000;
    bus.rf_stall = 1'b0;

    // reset with all requesting
    cyc(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0, "rst0");
    cyc(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0, "rst1");
    // all four, each drops after its grant
    cyc(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 1, "all_g0");
    cyc(0, 4'b1110, 0, 4'b0010, 2'd1, 1, 2, "all_g1");
    cyc(0, 4'b1100, 0, 4'b0100, 2'd2, 1, 3, "all_g2");
    cyc(0, 4'b1000, 0, 4'b1000, 2'd3, 0, 4, "all_g3");
    cyc(0, 4'b0000, 0, 4'b0000, 2'd3, 0, 4, "all_idle");
    // single requester
    cyc(0, 4'b0100, 0, 4'b0100, 2'd2, 0, 5, "single_g");
    cyc(0, 4'b0000, 0, 4'b0000, 2'd2, 0, 5, "single_idle");
    // rotation: producer 1 wins, then 0 and 1 both held
    cyc(0, 4'b0010, 0, 4'b0010, 2'd1, 0, 6, "rot_p1");
    cyc(0, 4'b0011, 0, 4'b0001, 2'd0, 0, 7, "rot_a");
    cyc(0, 4'b0011, 0, 4'b0010, 2'd1, 0, 8, "rot_b");
    cyc(0, 4'b0011, 0, 4'b0001, 2'd0, 0, 9, "rot_c");
    cyc(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 9, "rot_idle");
    // stall for three cycles
    cyc(0, 4'b1000, 1, 4'b0000, 2'd0, 1, 9, "stall0");
    cyc(0, 4'b1000, 1, 4'b0000, 2'd0, 1, 9, "stall1");
    cyc(0, 4'b1000, 1, 4'b0000, 2'd0, 1, 9, "stall2");
    cyc(0, 4'b1000, 0, 4'b1000, 2'd3, 0, 10, "stall_release");
    cyc(0, 4'b0000, 0, 4'b0000, 2'd3, 0, 10, "stall_idle");
    // back-to-back single producer, reset mid-stream
    cyc(0, 4'b0001, 0, 4'b0001, 2'd0, 0, 11, "b2b0");
    cyc(0, 4'b0001, 0, 4'b0000, 2'd0, 0, 11, "b2b1");
    cyc(0, 4'b0001, 0, 4'b0001, 2'd0, 0, 12, "b2b2");
    cyc(0, 4'b0001, 0, 4'b0000, 2'd0, 0, 12, "b2b3");
    cyc(0, 4'b0001, 0, 4'b0001, 2'd0, 0, 13, "b2b4");
    cyc(1, 4'b0001, 0, 4'b0000, 2'd0, 0, 0, "b2b_rst");
    cyc(0, 4'b0001, 0, 4'b0001, 2'd0, 0, 1, "post_rst_g");
    cyc(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 1, "post_rst_idle");
    // counter wrap: 0 and 1 held, alternating grants, count runs 2..16 (mod 16)
    for (int i = 0; i < 15; i++) begin
      cyc(0, 4'b0011, 0, (i % 2 == 0) ? 4'b0010 : 4'b0001,
          (i % 2 == 0) ? 2'd1 : 2'd0, (i == 0), (2 + i) % 16, "wrap");
    end
    cyc(0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0, "wrap_idle");
    cyc(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "final_rst");

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
